// File: rtl/mdu_ctrl_pkg.sv
// Shared types and constants for the multiply/divide unit sequencer.
package mdu_ctrl_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OP_W  = 3;

    // MDU operation encodings driven by the decoder into the E stage.
    typedef enum logic [OP_W-1:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5,
        MDU_MFHI  = 3'd6,
        MDU_MFLO  = 3'd7
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    // 64-bit result payload split into the architectural halves.
    typedef struct packed {
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
    } mdu_res_t;

    // True for the four ops that open a busy window (mult/multu/div/divu).
    function automatic logic is_muldiv(input logic [OP_W-1:0] op);
        return ~op[2];
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Pipeline <-> MDU signal bundle; master is the pipeline, slave is the MDU.
interface mdu_ctrl_if;
    import mdu_ctrl_pkg::*;

    logic                 req;
    logic [OP_W-1:0]      op;
    logic [XLEN-1:0]      a;
    logic [XLEN-1:0]      b;
    logic                 cancel;
    logic                 md_d;
    logic                 busy;
    logic                 start;
    logic                 stall_d;
    logic [XLEN-1:0]      rd;
    logic [XLEN-1:0]      hi;
    logic [XLEN-1:0]      lo;

    modport master (
        output req, op, a, b, cancel, md_d,
        input  busy, start, stall_d, rd, hi, lo
    );

    modport slave (
        input  req, op, a, b, cancel, md_d,
        output busy, start, stall_d, rd, hi, lo
    );

endinterface

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath producing {hi,lo} for mult/multu/div/divu.
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output mdu_res_t        res,
    output logic            div_zero
);

    localparam int unsigned PW = 2 * XLEN;

    logic            sgn;
    logic            is_div;
    logic [PW-1:0]   ext_a;
    logic [PW-1:0]   ext_b;
    logic [PW-1:0]   prod;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic [XLEN-1:0] div_b;
    logic [XLEN-1:0] q_mag;
    logic [XLEN-1:0] r_mag;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;

    // Division works on magnitudes and re-applies signs, so 0x80000000/-1 needs no special case.
    always_comb begin
        sgn      = ~op[0];
        is_div   = op[1];
        ext_a    = {{XLEN{sgn & a[XLEN-1]}}, a};
        ext_b    = {{XLEN{sgn & b[XLEN-1]}}, b};
        prod     = PW'(ext_a * ext_b);
        mag_a    = (sgn & a[XLEN-1]) ? XLEN'(-a) : a;
        mag_b    = (sgn & b[XLEN-1]) ? XLEN'(-b) : b;
        div_zero = is_div & (b == '0);
        div_b    = (mag_b == '0) ? XLEN'(1) : mag_b;
        q_mag    = mag_a / div_b;
        r_mag    = mag_a % div_b;
        quo      = (sgn & (a[XLEN-1] ^ b[XLEN-1])) ? XLEN'(-q_mag) : q_mag;
        rem      = (sgn & a[XLEN-1]) ? XLEN'(-r_mag) : r_mag;
        res      = is_div ? mdu_res_t'({rem, quo}) : mdu_res_t'(prod);
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for the E stage: busy window, HI/LO commit, mt/mf, D-stage stall.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
)
(
    input  logic       clk,
    input  logic       reset,
    mdu_ctrl_if.slave  bus
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e      state_q;
    mdu_state_e      state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    mdu_res_t        pend_q;
    logic            pend_zero_q;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;

    mdu_op_e         op_c;
    mdu_res_t        res_c;
    logic            div_zero_c;
    logic            busy_c;
    logic            take_c;
    logic            start_c;
    logic            commit_c;

    mdu_arith u_arith (
        .op       (bus.op[1:0]),
        .a        (bus.a),
        .b        (bus.b),
        .res      (res_c),
        .div_zero (div_zero_c)
    );

    // Acceptance decode: any MDU op is taken only when not cancelled and not busy.
    assign op_c     = mdu_op_e'(bus.op);
    assign busy_c   = (state_q == ST_BUSY);
    assign take_c   = bus.req & ~bus.cancel & ~busy_c;
    assign start_c  = take_c & is_muldiv(bus.op);
    assign commit_c = busy_c & (cnt_q == CNT_W'(1));

    // Next-state and counter: load the op's latency on start, count down to commit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_c) begin
                    state_d = ST_BUSY;
                    cnt_d   = bus.op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                end
            end
            ST_BUSY: begin
                if (commit_c) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the result at start; it sits here until the busy window ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q      <= '0;
            pend_zero_q <= 1'b0;
        end else if (start_c) begin
            pend_q      <= res_c;
            pend_zero_q <= div_zero_c;
        end
    end

    // HI/LO: commit of a finished op (skipped on divide by zero), or a direct mthi/mtlo.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (commit_c) begin
            if (!pend_zero_q) begin
                hi_q <= pend_q.hi;
                lo_q <= pend_q.lo;
            end
        end else if (take_c && op_c == MDU_MTHI) begin
            hi_q <= bus.a;
        end else if (take_c && op_c == MDU_MTLO) begin
            lo_q <= bus.a;
        end
    end

    // Output drive.
    assign bus.busy    = busy_c;
    assign bus.start   = start_c;
    assign bus.stall_d = bus.md_d & (busy_c | start_c);
    assign bus.rd      = (op_c == MDU_MFHI) ? hi_q : lo_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;

endmodule
